// File: rtl/cheat_code_loader.sv
// -----------------------------------------------------------------------------
// cheat_code_loader
//   Upstream feeder for the cheat-code engine. Assembles a byte stream from the
//   host data loader into 16-byte records, presents each one as a 129-bit code
//   word with a clean strobe on bit 128, and pulses the engine clear at the
//   start of every download.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   load_active  high while the host streams a cheat file
//   in_valid     byte-stream valid
//   in_data      record byte (offset within record = arrival order)
//   in_ready     byte accepted when in_valid && in_ready
//   code_out     {strobe, flags[31:0], addr[31:0], compare[31:0], replace[31:0]}
//   codes_reset  clear pulse to the engine
//   code_count   codes issued since last download start (saturating)
//   partial_err  sticky: download ended with a partial record
// -----------------------------------------------------------------------------
module cheat_code_loader #(
  parameter int HOLD_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_active,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [128:0]         code_out,
  output logic                 codes_reset,
  output logic [CNT_WIDTH-1:0] code_count,
  output logic                 partial_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    STROBE_HI,
    STROBE_LO
  } state_t;

  localparam int TMR_MAX = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYCLES - 1);

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [3:0]           idx_q, idx_d;
  logic [127:0]         data_q, data_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 perr_q, perr_d;
  logic                 load_q, load_d;
  logic                 load_rise;
  logic                 accept;

  // Bytes are only taken while the download is steadily active; a cycle in
  // which load_active has just risen restarts the download instead.
  assign in_ready    = (state_q == COLLECT) && load_active && load_q;
  assign accept      = in_ready && in_valid;
  assign load_rise   = load_active && !load_q;
  assign code_out    = {(state_q == STROBE_HI), data_q};
  assign codes_reset = (state_q == CLEAR);
  assign code_count  = count_q;
  assign partial_err = perr_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    perr_d  = perr_q;
    load_d  = load_active;

    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == CLEAR_LAST) begin
          state_d = COLLECT;
          tmr_d   = '0;
        end
      end
      COLLECT: begin
        if (!load_active) begin
          // Download ended; any half-built record is thrown away.
          state_d = IDLE;
          idx_d   = '0;
          data_d  = '0;
          if (idx_q != 4'd0) perr_d = 1'b1;
        end else if (accept) begin
          for (int k = 0; k < 16; k++) begin
            if (idx_q == 4'(k)) data_d[127-8*k -: 8] = in_data;
          end
          idx_d = idx_q + 4'd1;  // wraps to 0 after the 16th byte
          if (idx_q == 4'd15) begin
            state_d = STROBE_HI;
            tmr_d   = '0;
            if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      STROBE_HI: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == HOLD_LAST) begin
          state_d = STROBE_LO;
          tmr_d   = '0;
        end
      end
      STROBE_LO: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == HOLD_LAST) begin
          state_d = load_active ? COLLECT : IDLE;
          tmr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new download overrides everything, including an in-flight strobe.
    if (load_rise) begin
      state_d = CLEAR;
      tmr_d   = '0;
      idx_d   = '0;
      data_d  = '0;
      count_d = '0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
      perr_q  <= perr_d;
      load_q  <= load_d;
    end
  end

endmodule
